// File: rtl/design_1_wrapper.sv
// LED heartbeat: drives the LED bus only after a boot delay, then counts 0..15 every PRESCALE clocks.
// Latency: LED bus driven BOOT_CYCLES edges after reset release; no backpressure (free-running output).
module design_1_wrapper #(
   parameter int unsigned BOOT_CYCLES = 16,  // edges after reset release before the LED bus is driven (1..65535)
   parameter int unsigned PRESCALE    = 100  // clock edges per LED count step (1..2^24-1)
) (
   input  logic       sys_clock,
   input  logic       reset,
   output logic [3:0] led_4bits_tri_o
);

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [15:0] BOOT_LAST  = 16'(BOOT_CYCLES - 1);
   localparam logic [23:0] PRESC_LAST = 24'(PRESCALE - 1);

   state_t      state_q, state_d;
   logic [15:0] boot_cnt_q, boot_cnt_d;
   logic [23:0] presc_cnt_q, presc_cnt_d;
   logic [3:0]  led_reg_q, led_reg_d;
   logic        oe_q, oe_d;

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      presc_cnt_d = presc_cnt_q;
      led_reg_d   = led_reg_q;
      oe_d        = oe_q;

      if (state_q == ST_BOOT) begin
         boot_cnt_d = boot_cnt_q + 16'd1;
         if (boot_cnt_q == BOOT_LAST) begin
            state_d     = ST_RUN;
            oe_d        = 1'b1;
            led_reg_d   = 4'd0;
            presc_cnt_d = 24'd0;
         end
      end else begin
         // Terminal count restarts the prescaler so every LED value is held exactly PRESCALE edges.
         if (presc_cnt_q == PRESC_LAST) begin
            presc_cnt_d = 24'd0;
            led_reg_d   = led_reg_q + 4'd1;
         end else begin
            presc_cnt_d = presc_cnt_q + 24'd1;
         end
      end
   end

   always_ff @(posedge sys_clock) begin
      if (!reset) begin
         state_q     <= ST_BOOT;
         boot_cnt_q  <= 16'd0;
         presc_cnt_q <= 24'd0;
         led_reg_q   <= 4'd0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         presc_cnt_q <= presc_cnt_d;
         led_reg_q   <= led_reg_d;
         oe_q        <= oe_d;
      end
   end

   // Output comes straight from flops, so reset has no combinational path to the pins.
   assign led_4bits_tri_o = oe_q ? led_reg_q : 4'bzzzz;

endmodule

// File: tb/tb_design_1_wrapper.sv
// Bench for design_1_wrapper: three parameterisations share one reset; pull-up nets read an undriven bus as 4'hf.
module tb_design_1_wrapper;

   logic sys_clock;
   logic reset;

   tri1 [3:0] led_def;   // BOOT_CYCLES=16, PRESCALE=100
   tri1 [3:0] led_fast;  // BOOT_CYCLES=1,  PRESCALE=1
   tri1 [3:0] led_mid;   // BOOT_CYCLES=3,  PRESCALE=2

   design_1_wrapper #(.BOOT_CYCLES(16), .PRESCALE(100)) u_def (
      .sys_clock(sys_clock), .reset(reset), .led_4bits_tri_o(led_def));
   design_1_wrapper #(.BOOT_CYCLES(1), .PRESCALE(1)) u_fast (
      .sys_clock(sys_clock), .reset(reset), .led_4bits_tri_o(led_fast));
   design_1_wrapper #(.BOOT_CYCLES(3), .PRESCALE(2)) u_mid (
      .sys_clock(sys_clock), .reset(reset), .led_4bits_tri_o(led_mid));

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: edges with reset high since the last edge that sampled reset low.
   int n_rel = 0;

   function automatic logic [3:0] model_led(input int n, input int boot, input int presc);
      if (n < boot) return 4'hf;
      return 4'((((n - boot) / presc) % 16));
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h (edges since release %0d)", name, act, exp, n_rel);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "/def"},  led_def,  model_led(n_rel, 16, 100));
      check({tag, "/fast"}, led_fast, model_led(n_rel, 1, 1));
      check({tag, "/mid"},  led_mid,  model_led(n_rel, 3, 2));
   endtask

   task automatic step(input logic r);
      reset = r;
      @(posedge sys_clock);
      #1;
      if (r == 1'b0) n_rel = 0;
      else n_rel++;
   endtask

   task automatic steps(input logic r, input int k);
      for (int i = 0; i < k; i++) step(r);
   endtask

   typedef struct {
      string      name;
      int         rst_cycles;
      int         run_cycles;
      logic [3:0] exp_def;
      logic [3:0] exp_fast;
      logic [3:0] exp_mid;
   } vec_t;

   vec_t vecs[9];

   initial begin
      reset = 1'b0;

      vecs[0] = '{"long_reset",   1000, 0,    4'hf, 4'hf, 4'hf};
      vecs[1] = '{"boot_15",      1,    15,   4'hf, 4'he, 4'h6};
      vecs[2] = '{"boot_16",      1,    16,   4'h0, 4'hf, 4'h6};
      vecs[3] = '{"boot_17",      1,    17,   4'h0, 4'h0, 4'h7};
      vecs[4] = '{"hold_end_0",   1,    115,  4'h0, 4'h2, 4'h8};
      vecs[5] = '{"step_to_1",    1,    116,  4'h1, 4'h3, 4'h8};
      vecs[6] = '{"value_5",      2,    516,  4'h5, 4'h3, 4'h0};
      vecs[7] = '{"last_15",      1,    1615, 4'hf, 4'he, 4'h6};
      vecs[8] = '{"wrap_to_0",    1,    1616, 4'h0, 4'hf, 4'h6};

      for (int v = 0; v < 9; v++) begin
         steps(1'b0, vecs[v].rst_cycles);
         check({vecs[v].name, "/in_reset"}, led_def, 4'hf);
         steps(1'b1, vecs[v].run_cycles);
         check({vecs[v].name, "/def"},  led_def,  vecs[v].exp_def);
         check({vecs[v].name, "/fast"}, led_fast, vecs[v].exp_fast);
         check({vecs[v].name, "/mid"},  led_mid,  vecs[v].exp_mid);
      end

      // Full free run: every edge of two complete LED cycles checked against the model.
      steps(1'b0, 3);
      for (int i = 0; i < 16 + 3300; i++) begin
         step(1'b1);
         check_model("freerun");
      end

      // One-cycle reset pulse while the default LED shows 4'b0101.
      steps(1'b0, 2);
      steps(1'b1, 16 + 500);
      check("pulse/pre", led_def, 4'h5);
      step(1'b0);
      check("pulse/z_after", led_def, 4'hf);
      steps(1'b1, 15);
      check("pulse/boot15", led_def, 4'hf);
      step(1'b1);
      check("pulse/boot16", led_def, 4'h0);
      steps(1'b1, 99);
      check("pulse/hold99", led_def, 4'h0);
      step(1'b1);
      check("pulse/inc", led_def, 4'h1);

      // Reset on the boot-complete edge must win.
      steps(1'b0, 1);
      steps(1'b1, 15);
      step(1'b0);
      check("boot_edge/def", led_def, 4'hf);
      steps(1'b1, 15);
      check("boot_edge/restart15", led_def, 4'hf);
      step(1'b1);
      check("boot_edge/restart16", led_def, 4'h0);

      // Reset on the prescale terminal-count edge must win with no increment.
      steps(1'b1, 99);
      check("tc_edge/pre", led_def, 4'h0);
      step(1'b0);
      check("tc_edge/def", led_def, 4'hf);
      check("tc_edge/fast", led_fast, 4'hf);
      check("tc_edge/mid", led_mid, 4'hf);
      steps(1'b1, 16);
      check("tc_edge/reboot_def", led_def, 4'h0);
      check("tc_edge/reboot_fast", led_fast, 4'hf);

      // Randomised reset activity against the model.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
         check_model("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/design_1_wrapper.md
DESIGN_1_WRAPPER -- requirements
Module: design_1_wrapper

Interface
REQ-001 Parameters SHALL be declared one per line as name, default, meaning:
- BOOT_CYCLES, 16, number of clock edges with reset released before the LED outputs are enabled (legal range 1..65535).
- PRESCALE, 100, clock edges per LED count step (legal range 1..2^24-1).

REQ-002 Ports SHALL be declared one per line as name, direction, width, meaning:
- sys_clock, input, 1, single system clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-low reset.
- led_4bits_tri_o, output, 4, tri-state LED bus; board pull-ups read undriven bits as 1.

REQ-003 The block SHALL use one clock (sys_clock), and reset SHALL be synchronous and active-low.
REQ-004 There SHALL be no other ports and no combinational path from reset to led_4bits_tri_o.

Function
REQ-005 Internal state SHALL consist of:
- state: BOOT or RUN.
- boot_cnt: 16 bits.
- presc_cnt: 24 bits.
- led_reg: 4 bits.
- oe: 1 bit.
REQ-006 led_4bits_tri_o SHALL equal led_reg when oe=1, and 4'bzzzz when oe=0.
REQ-007 In BOOT, each rising edge with reset=1 SHALL increment boot_cnt.
REQ-008 At the edge where boot_cnt==BOOT_CYCLES-1, the block SHALL set state=RUN, oe=1, led_reg=0 and presc_cnt=0.
REQ-009 The LED bus SHALL therefore be driven 4'b0000 starting BOOT_CYCLES edges after the first edge sampling reset=1.
REQ-010 In RUN, each edge SHALL increment presc_cnt.
REQ-011 At the edge where presc_cnt==PRESCALE-1, the block SHALL set presc_cnt=0 and led_reg=led_reg+1 (modulo 16).
REQ-012 Each LED value SHALL be held for exactly PRESCALE cycles.
REQ-013 Wrap-around: led_reg SHALL go from 4'b1111 to 4'b0000 with no extra hold cycle, and oe SHALL stay 1.
REQ-014 When PRESCALE=1, led_reg SHALL increment on every edge in RUN.
REQ-015 When BOOT_CYCLES=1, RUN SHALL be entered on the first edge with reset=1.
REQ-016 In RUN, oe SHALL never deassert except by reset.
REQ-017 All state SHALL change only on rising edges of sys_clock, with no latches and no gated clocks.

Reset
REQ-018 On any rising edge sampling reset=0, the block SHALL set state=BOOT, boot_cnt=0, presc_cnt=0, led_reg=0 and oe=0.
REQ-019 During reset and BOOT, led_4bits_tri_o SHALL be 4'bzzzz, which reads 4'b1111 with pull-ups.
REQ-020 Reset SHALL take priority over all other events, including the boot-complete edge and a prescale terminal count on the same edge.
REQ-021 Reset asserted mid-RUN SHALL return the outputs to Z on the following edge and restart the full boot sequence after release.
REQ-022 Reset held for any length, including 1000 cycles, SHALL have no side effect beyond REQ-018.

Verification
REQ-023 Reset low for 1000 cycles, then high:
- led_4bits_tri_o reads 4'b1111 (Z) throughout reset and for the first 15 edges after release.
- It reads 4'b0000 after the 16th edge.
REQ-024 Free-run after boot with defaults:
- Values 0,1,2,...,15 each held exactly 100 cycles.
- 15 followed directly by 0 (wrap-around).
REQ-025 Reset pulsed low for 1 cycle while led=4'b0101:
- Output is Z after that edge.
- 4'b0000 is driven 16 edges after release.
- Increment to 4'b0001 occurs 100 cycles later.
REQ-026 Parameters BOOT_CYCLES=1, PRESCALE=1:
- 4'b0000 after the first edge with reset high.
- Then increments every cycle: 0,1,2,...,15,0.
REQ-027 Reset asserted on the exact edge where boot_cnt==BOOT_CYCLES-1, or where presc_cnt==PRESCALE-1:
- Reset wins; oe=0 and led_reg=0 after that edge.
- No increment occurs.
